// File: rtl/la_pwrseq.sv
// la_pwrseq: steps N power/decap banks on or off one at a time, delay+1 cycles apart.
// Defining LA_PWRSEQ_STATUS_EN adds a 'level' output that reports how many banks are enabled.
module la_pwrseq #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [DW-1:0] delay,
    output logic [N-1:0]  en,
    output logic          ack,
    output logic          busy
`ifdef LA_PWRSEQ_STATUS_EN
    ,
    output logic [$clog2(N+1)-1:0] level
`endif
);
    localparam int LW = $clog2(N+1);
    localparam logic [LW-1:0] LvlMax = LW'(N);

    typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_e;

    state_e        state_q;
    logic [LW-1:0] level_q;
    logic [DW-1:0] timer_q;
    logic [LW-1:0] levelInc_d;
    logic [LW-1:0] levelDec_d;
    logic          unusedProp;

    // PROP only tags the technology flavour and never steers behaviour.
    assign unusedProp = |PROP;

    assign levelInc_d = level_q + LW'(1);
    assign levelDec_d = level_q - LW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            level_q <= '0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    if (req) begin
                        level_q <= LW'(1);
                        timer_q <= delay;
                        state_q <= (N == 1) ? ON : UP;
                    end
                end
                UP: begin
                    if (!req) begin
                        state_q <= DOWN;
                        timer_q <= delay;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - DW'(1);
                    end else begin
                        level_q <= levelInc_d;
                        timer_q <= delay;
                        if (levelInc_d == LvlMax) state_q <= ON;
                    end
                end
                ON: begin
                    if (!req) begin
                        level_q <= levelDec_d;
                        timer_q <= delay;
                        state_q <= (N == 1) ? OFF : DOWN;
                    end
                end
                DOWN: begin
                    // A reversal keeps the current level so no bank toggles twice.
                    if (req) begin
                        state_q <= UP;
                        timer_q <= delay;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - DW'(1);
                    end else begin
                        level_q <= levelDec_d;
                        timer_q <= delay;
                        if (levelDec_d == '0) state_q <= OFF;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_en
        assign en[i] = (level_q > LW'(i));
    end

    assign ack  = (state_q == ON);
    assign busy = (state_q == UP) || (state_q == DOWN);

`ifdef LA_PWRSEQ_STATUS_EN
    assign level = level_q;
`endif

endmodule

// File: tb/tb_la_pwrseq.sv
// tb_la_pwrseq: scoreboard bench for la_pwrseq with N=4, N=8 and N=1 instances.
// Stimulus pushes hand-derived expectations; a monitor pops and compares one per cycle.
module tb_la_pwrseq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req4 = 1'b0;
    logic       req8 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] delay = 8'd0;
    logic [3:0] en4;
    logic [7:0] en8;
    logic [0:0] en1;
    logic       ack4, ack8, ack1;
    logic       busy4, busy8, busy1;
`ifdef LA_PWRSEQ_STATUS_EN
    logic [2:0] lvl4;
    logic [3:0] lvl8;
    logic [0:0] lvl1;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         sel;
        logic [7:0] en;
        logic       ack;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    la_pwrseq #(.N(4), .DW(8), .PROP("DEFAULT")) dut4 (
        .clk(clk), .rst(rst), .req(req4), .delay(delay),
        .en(en4), .ack(ack4), .busy(busy4)
`ifdef LA_PWRSEQ_STATUS_EN
        , .level(lvl4)
`endif
    );

    la_pwrseq #(.N(8), .DW(8), .PROP("LOWLEAK")) dut8 (
        .clk(clk), .rst(rst), .req(req8), .delay(delay),
        .en(en8), .ack(ack8), .busy(busy8)
`ifdef LA_PWRSEQ_STATUS_EN
        , .level(lvl8)
`endif
    );

    la_pwrseq #(.N(1), .DW(8), .PROP("DEFAULT")) dut1 (
        .clk(clk), .rst(rst), .req(req1), .delay(delay),
        .en(en1), .ack(ack1), .busy(busy1)
`ifdef LA_PWRSEQ_STATUS_EN
        , .level(lvl1)
`endif
    );

    // Drives one cycle of inputs for the selected instance and queues what it must show after the edge.
    task automatic applyStimulus(input int sel, input logic r, input logic q, input logic [7:0] d,
                                 input logic [7:0] e, input logic a, input logic b, input string tag);
        exp_t x;
        @(negedge clk);
        rst   = r;
        delay = d;
        req4  = (sel == 0) ? q : 1'b0;
        req8  = (sel == 1) ? q : 1'b0;
        req1  = (sel == 2) ? q : 1'b0;
        x.sel = sel; x.en = e; x.ack = a; x.busy = b; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        logic [7:0] actEn;
        logic       actAck, actBusy;
        int         actLvl, expLvl;
        bit         bad;
        case (x.sel)
            0:       begin actEn = {4'd0, en4}; actAck = ack4; actBusy = busy4; end
            1:       begin actEn = en8;         actAck = ack8; actBusy = busy8; end
            default: begin actEn = {7'd0, en1}; actAck = ack1; actBusy = busy1; end
        endcase
        expLvl = $countones(x.en);
        actLvl = expLvl;
`ifdef LA_PWRSEQ_STATUS_EN
        case (x.sel)
            0:       actLvl = int'(lvl4);
            1:       actLvl = int'(lvl8);
            default: actLvl = int'(lvl1);
        endcase
`endif
        bad = (actEn !== x.en) || (actAck !== x.ack) || (actBusy !== x.busy) || (actLvl != expLvl);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got en=%h ack=%b busy=%b level=%0d, expected en=%h ack=%b busy=%b level=%0d",
                     x.tag, actEn, actAck, actBusy, actLvl, x.en, x.ack, x.busy, expLvl);
        end
    endtask

    // Monitor: one expectation is due shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        logic [7:0] e;
        int         waited;
        logic [7:0] pulses;

        applyStimulus(0, 1'b1, 1'b0, 8'd2, 8'h0, 1'b0, 1'b0, "reset4");
        applyStimulus(1, 1'b1, 1'b0, 8'd2, 8'h0, 1'b0, 1'b0, "reset8");
        applyStimulus(2, 1'b1, 1'b0, 8'd2, 8'h0, 1'b0, 1'b0, "reset1");
        applyStimulus(0, 1'b0, 1'b0, 8'd2, 8'h0, 1'b0, 1'b0, "idle_off");

        // Power-up, delay 2: a new bank every third edge.
        for (int k = 0; k < 10; k++) begin
            e = (k < 3) ? 8'h1 : (k < 6) ? 8'h3 : (k < 9) ? 8'h7 : 8'hF;
            applyStimulus(0, 1'b0, 1'b1, 8'd2, e, k == 9, k < 9, "powerup");
        end
        applyStimulus(0, 1'b0, 1'b1, 8'd2, 8'hF, 1'b1, 1'b0, "hold_on");
        applyStimulus(0, 1'b0, 1'b1, 8'd2, 8'hF, 1'b1, 1'b0, "hold_on");

        for (int k = 0; k < 10; k++) begin
            e = (k < 3) ? 8'h7 : (k < 6) ? 8'h3 : (k < 9) ? 8'h1 : 8'h0;
            applyStimulus(0, 1'b0, 1'b0, 8'd2, e, 1'b0, k < 9, "powerdown");
        end

        // Reversal at en=0011: level is held, then steps back down.
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 1'b0, 1'b1, 8'd2, (k < 3) ? 8'h1 : 8'h3, 1'b0, 1'b1, "rev_up");
        for (int k = 4; k < 11; k++) begin
            e = (k < 7) ? 8'h3 : (k < 10) ? 8'h1 : 8'h0;
            applyStimulus(0, 1'b0, 1'b0, 8'd2, e, 1'b0, k < 10, "rev_down");
        end

        // Reset mid-UP, then a mid-step delay change that must not stretch the step.
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 1'b0, 1'b1, 8'd2, (k < 3) ? 8'h1 : 8'h3, 1'b0, 1'b1, "pre_reset");
        applyStimulus(0, 1'b1, 1'b1, 8'd2, 8'h0, 1'b0, 1'b0, "mid_reset");
        applyStimulus(0, 1'b0, 1'b1, 8'd1, 8'h1, 1'b0, 1'b1, "restart");
        applyStimulus(0, 1'b0, 1'b1, 8'd7, 8'h1, 1'b0, 1'b1, "delay_change");
        applyStimulus(0, 1'b0, 1'b1, 8'd7, 8'h3, 1'b0, 1'b1, "delay_load7");
        for (int k = 0; k < 7; k++)
            applyStimulus(0, 1'b0, 1'b1, 8'd0, 8'h3, 1'b0, 1'b1, "long_step");
        applyStimulus(0, 1'b0, 1'b1, 8'd0, 8'h7, 1'b0, 1'b1, "after_long");
        applyStimulus(0, 1'b0, 1'b1, 8'd0, 8'hF, 1'b1, 1'b0, "on_again");
        applyStimulus(0, 1'b1, 1'b1, 8'd0, 8'h0, 1'b0, 1'b0, "reset_from_on");

        // N=8 with zero delay: one bank per cycle each way.
        for (int k = 0; k < 8; k++)
            applyStimulus(1, 1'b0, 1'b1, 8'd0, 8'((1 << (k + 1)) - 1), k == 7, k < 7, "n8_up");
        for (int k = 0; k < 8; k++)
            applyStimulus(1, 1'b0, 1'b0, 8'd0, 8'(255 >> (k + 1)), 1'b0, k < 7, "n8_down");

        // N=1: en and ack track req one cycle later, never busy.
        pulses = 8'b0100_1011;
        for (int k = 0; k < 8; k++)
            applyStimulus(2, 1'b0, pulses[k], 8'd3, {7'd0, pulses[k]}, pulses[k], 1'b0, "n1_pulse");

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
